// File: rtl/cdb_wb_arbiter_pkg.sv
// Shared types and source indices for the CDB writeback arbiter.
// The source indices are also used by the issue stage.
package cdb_wb_arbiter_pkg;

    localparam int NUM_CDB_SRC = 6;
    localparam int CDB_SIZE    = 5;
    localparam int BUF_DEPTH   = 2;

    localparam int SRC_ALU = 0;
    localparam int SRC_MUL = 1;
    localparam int SRC_DIV = 2;
    localparam int SRC_BR  = 3;
    localparam int SRC_LD  = 4;
    localparam int SRC_ST  = 5;

    typedef struct packed {
        logic        valid;
        logic [4:0]  rd_addr;
        logic [5:0]  rd_paddr;
        logic [31:0] rd_data;
    } cdb_t;

endpackage

// File: rtl/cdb_wb_arbiter_if.sv
// Producer-side results, backpressure, squash and the registered CDB lanes.
interface cdb_wb_arbiter_if import cdb_wb_arbiter_pkg::*; #(
    parameter int NUM_SRC = NUM_CDB_SRC
);

    logic               flush;
    cdb_t               src_res [NUM_SRC];
    logic [NUM_SRC-1:0] src_ready;
    cdb_t               cdb [CDB_SIZE];

    modport master (output flush, output src_res, input src_ready, input cdb);
    modport slave  (input flush, input src_res, output src_ready, output cdb);

endinterface

// File: rtl/cdb_wb_arbiter_src_fifo.sv
// Two-entry result buffer for one producer; entries are stored unmodified.
module cdb_src_fifo import cdb_wb_arbiter_pkg::*; (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic push,
    input  logic pop,
    input  cdb_t din,
    output logic full,
    output logic empty,
    output cdb_t head
);

    cdb_t       mem [BUF_DEPTH];
    logic       rd_ptr;
    logic       wr_ptr;
    logic [1:0] count;
    logic       do_push;
    logic       do_pop;

    assign full    = (count == 2'(BUF_DEPTH));
    assign empty   = (count == 2'd0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + 2'(do_push) - 2'(do_pop);
        end
    end

endmodule

// File: rtl/cdb_wb_arbiter.sv
// Round-robin writeback arbiter: per-source buffers feed up to CDB_SIZE
// registered broadcast lanes per cycle.
module cdb_wb_arbiter import cdb_wb_arbiter_pkg::*; #(
    parameter int NUM_SRC = NUM_CDB_SRC
) (
    input logic            clk,
    input logic            rst,
    cdb_wb_arbiter_if.slave bus
);

    localparam int PTR_W  = $clog2(NUM_SRC);
    localparam int LANE_W = $clog2(CDB_SIZE);
    localparam int CNT_W  = $clog2(CDB_SIZE + 1);
    localparam logic [PTR_W:0]   NSRC_W   = (PTR_W+1)'(NUM_SRC);
    localparam logic [PTR_W-1:0] LAST_SRC = PTR_W'(NUM_SRC - 1);
    localparam logic [CNT_W-1:0] LANES    = CNT_W'(CDB_SIZE);

    logic [NUM_SRC-1:0] full;
    logic [NUM_SRC-1:0] empty;
    logic [NUM_SRC-1:0] ready;
    logic [NUM_SRC-1:0] push;
    logic [NUM_SRC-1:0] pop;
    logic [NUM_SRC-1:0] grant;
    cdb_t               head [NUM_SRC];
    cdb_t               lane_nxt [CDB_SIZE];
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   rr_nxt;

    // Ready comes from registered occupancy only; a same-cycle pop gives no credit.
    assign ready         = ~full & {NUM_SRC{~rst}};
    assign bus.src_ready = ready;
    assign pop           = grant & ~{NUM_SRC{bus.flush}};

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        assign push[i] = bus.src_res[i].valid && ready[i] && !bus.flush;

        cdb_src_fifo u_fifo (
            .clk   (clk),
            .rst   (rst),
            .clear (bus.flush),
            .push  (push[i]),
            .pop   (pop[i]),
            .din   (bus.src_res[i]),
            .full  (full[i]),
            .empty (empty[i]),
            .head  (head[i])
        );
    end

    always_comb begin : arb
        logic [PTR_W:0]   sum;
        logic [PTR_W-1:0] idx;
        logic [CNT_W-1:0] n;
        grant    = '0;
        rr_nxt   = rr_ptr;
        lane_nxt = '{default: '0};
        n        = '0;
        sum      = '0;
        idx      = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            sum = {1'b0, rr_ptr} + (PTR_W+1)'(k);
            if (sum >= NSRC_W) begin
                sum = sum - NSRC_W;
            end
            idx = sum[PTR_W-1:0];
            if (!empty[idx] && (n < LANES)) begin
                grant[idx]                = 1'b1;
                lane_nxt[n[LANE_W-1:0]]   = head[idx];
                rr_nxt                    = (idx == LAST_SRC) ? '0 : idx + PTR_W'(1);
                n                         = n + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            rr_ptr  <= '0;
            bus.cdb <= '{default: '0};
        end else begin
            rr_ptr  <= rr_nxt;
            bus.cdb <= lane_nxt;
        end
    end

endmodule

// File: tb/tb_cdb_wb_arbiter.sv
// Scoreboard bench for cdb_wb_arbiter: per-source expected queues filled on
// handshake and matched against broadcast lanes, plus directed timing checks.
module tb_cdb_wb_arbiter;
    import cdb_wb_arbiter_pkg::*;

    localparam int NS = NUM_CDB_SRC;

    logic clk;
    logic rst;

    cdb_wb_arbiter_if #(.NUM_SRC(NS)) bus ();

    cdb_wb_arbiter #(.NUM_SRC(NS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail   = 0;
    cdb_t pend [NS][$];
    cdb_t sb   [NS][$];
    bit   took [NS];
    bit   bp_on      = 0;
    bit   drop_seen  = 0;
    int   acc2       = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic cdb_t mk(input int a, input int p, input logic [31:0] d);
        cdb_t r;
        r.valid    = 1'b1;
        r.rd_addr  = 5'(a);
        r.rd_paddr = 6'(p);
        r.rd_data  = d;
        return r;
    endfunction

    // Producer model: hold the front item until a handshake is seen.
    task automatic cycle();
        @(posedge clk);
        #1;
        for (int s = 0; s < NS; s++) begin
            if (took[s] && pend[s].size() > 0) void'(pend[s].pop_front());
            if (pend[s].size() > 0) bus.src_res[s] = pend[s][0];
            else                    bus.src_res[s] = '0;
        end
    endtask

    // Monitor: match valid lanes against queue fronts, then record handshakes.
    always @(negedge clk) begin
        bit hit;
        if (!rst) begin
            for (int l = 0; l < CDB_SIZE; l++) begin
                if (bus.cdb[l].valid) begin
                    if (l > 0) check_eq("lane_gap", 64'(bus.cdb[l-1].valid), 64'd1);
                    hit = 0;
                    for (int s = 0; s < NS; s++) begin
                        if (!hit && sb[s].size() > 0 && sb[s][0] == bus.cdb[l]) begin
                            hit = 1;
                            void'(sb[s].pop_front());
                        end
                    end
                    check_eq("sb_hit", 64'(hit), 64'd1);
                end
            end
        end
        if (bp_on && !drop_seen && bus.src_res[2].valid && !bus.src_ready[2]) begin
            drop_seen = 1;
            check_eq("bp_ready_drop_accepts", 64'(acc2), 64'd2);
        end
        for (int s = 0; s < NS; s++) begin
            took[s] = bus.src_res[s].valid && bus.src_ready[s];
            if (rst || bus.flush) sb[s].delete();
            else if (took[s])     sb[s].push_back(bus.src_res[s]);
        end
        if (bp_on && took[2]) acc2++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    initial begin
        int total;
        rst       = 1'b1;
        bus.flush = 1'b0;
        for (int s = 0; s < NS; s++) bus.src_res[s] = '0;

        repeat (3) begin
            @(negedge clk);
            check_eq("rst_ready", 64'(bus.src_ready), 64'd0);
            for (int l = 0; l < CDB_SIZE; l++) check_eq("rst_cdb", 64'(bus.cdb[l]), 64'd0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("rel_ready", 64'(bus.src_ready), 64'h3f);
        for (int l = 0; l < CDB_SIZE; l++) check_eq("rel_cdb", 64'(bus.cdb[l]), 64'd0);

        // Oversubscription from rr_ptr=0.
        for (int s = 0; s < NS; s++) pend[s].push_back(mk(s+1, s+10, 32'hA000_0000 + 32'(s)));
        repeat (3) cycle();
        @(negedge clk);
        for (int l = 0; l < CDB_SIZE; l++)
            check_eq("ovs_lane", 64'(bus.cdb[l]), 64'(mk(l+1, l+10, 32'hA000_0000 + 32'(l))));
        cycle();
        @(negedge clk);
        check_eq("ovs_src5_lane0", 64'(bus.cdb[0]), 64'(mk(6, 15, 32'hA000_0005)));
        check_eq("ovs_lane1_idle", 64'(bus.cdb[1].valid), 64'd0);

        // rr_ptr must have wrapped to 0: source 0 wins lane 0 over source 5.
        pend[5].push_back(mk(6, 50, 32'h0000_00B5));
        pend[0].push_back(mk(1, 51, 32'h0000_00B0));
        repeat (3) cycle();
        @(negedge clk);
        check_eq("rr_wrap_lane0", 64'(bus.cdb[0]), 64'(mk(1, 51, 32'h0000_00B0)));
        check_eq("rr_wrap_lane1", 64'(bus.cdb[1]), 64'(mk(6, 50, 32'h0000_00B5)));

        // Single result latency.
        pend[0].push_back(mk(5, 40, 32'hDEAD_BEEF));
        repeat (3) cycle();
        @(negedge clk);
        check_eq("single_lane0", 64'(bus.cdb[0]), 64'(mk(5, 40, 32'hDEAD_BEEF)));
        for (int l = 1; l < CDB_SIZE; l++) check_eq("single_other", 64'(bus.cdb[l].valid), 64'd0);
        cycle();
        @(negedge clk);
        check_eq("single_one_cycle", 64'(bus.cdb[0].valid), 64'd0);

        // x0 passthrough on source 2 (leaves rr_ptr at 3).
        pend[2].push_back(mk(0, 0, 32'd7));
        repeat (3) cycle();
        @(negedge clk);
        check_eq("x0_lane0", 64'(bus.cdb[0]), 64'(mk(0, 0, 32'd7)));
        check_eq("x0_lane1_idle", 64'(bus.cdb[1].valid), 64'd0);
        cycle();

        // Backpressure on source 2 behind five busy sources.
        for (int s = 0; s < NS; s++) begin
            if (s != 2) begin
                for (int k = 0; k < 4; k++)
                    pend[s].push_back(mk(s+1, s+16, 32'h0100_0000 * 32'(s+1) + 32'(k)));
            end
        end
        for (int k = 1; k <= 3; k++) pend[2].push_back(mk(2, 2, 32'(k)));
        drop_seen = 0;
        cycle();
        acc2  = 0;
        bp_on = 1;
        repeat (20) cycle();
        bp_on = 0;
        check_eq("bp_drop_seen", 64'(drop_seen), 64'd1);
        total = 0;
        for (int s = 0; s < NS; s++) total += pend[s].size();
        check_eq("bp_pend_drained", 64'(total), 64'd0);

        // Flush with four buffered results and a push in the flush cycle.
        for (int s = 0; s < 4; s++) pend[s].push_back(mk(s+1, 20+s, 32'hC000_0000 + 32'(s)));
        cycle();
        pend[4].push_back(mk(9, 60, 32'hF1F1_F1F1));
        pend[0].push_back(mk(9, 61, 32'hF0F0_F0F0));
        cycle();
        bus.flush = 1'b1;
        cycle();
        bus.flush = 1'b0;
        @(negedge clk);
        for (int l = 0; l < CDB_SIZE; l++) check_eq("flush_cdb1", 64'(bus.cdb[l].valid), 64'd0);
        check_eq("flush_ready", 64'(bus.src_ready), 64'h3f);
        cycle();
        @(negedge clk);
        for (int l = 0; l < CDB_SIZE; l++) check_eq("flush_cdb2", 64'(bus.cdb[l].valid), 64'd0);
        repeat (5) cycle();

        @(negedge clk);
        total = 0;
        for (int s = 0; s < NS; s++) total += sb[s].size();
        check_eq("sb_drain", 64'(total), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
